// File: rtl/hex_key_entry.sv
// Pushbutton hex entry: synchronizes and debounces KEY[2:0], edits a DATA_W-bit value one nibble at a time,
// and commits it over a valid/ready handshake. Define HEX_ENTRY_BLINK_EN to blink the digit under the cursor.
//
// state  | meaning
// S_EDIT | editing, a commit press latches edit_value into out_data
// S_HOLD | out_valid high, waiting for out_ready; edits continue, commits ignored
module hex_key_entry #(
  parameter  int DATA_W       = 8,
  parameter  int DEB_CYCLES   = 500000,
  parameter  int BLINK_CYCLES = 12500000,
  localparam int NDIG         = DATA_W / 4,
  localparam int CW           = (NDIG > 1) ? $clog2(NDIG) : 1
) (
  input  logic              CLK,
  input  logic              RST,
  input  logic [2:0]        KEY,
  output logic [DATA_W-1:0] out_data,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [DATA_W-1:0] edit_value,
  output logic [CW-1:0]     cursor,
  output logic [NDIG-1:0]   blank
);

  localparam int DEB_CW = $clog2(DEB_CYCLES + 1);
  localparam logic [DEB_CW-1:0] DEB_TC = DEB_CW'(DEB_CYCLES - 1);

  typedef enum logic {
    S_EDIT = 1'b0,
    S_HOLD = 1'b1
  } state_t;

  logic [2:0]        sync1_q, sync2_q;
  logic [2:0]        deb_q, deb_d;
  logic [DEB_CW-1:0] cnt_q [3];
  logic [DEB_CW-1:0] cnt_d [3];
  logic [2:0]        press_q, press_d;

  state_t            state_q, state_d;
  logic [DATA_W-1:0] edit_q, edit_d;
  logic [DATA_W-1:0] out_data_q, out_data_d;
  logic              out_valid_q, out_valid_d;
  logic [CW-1:0]     cursor_q, cursor_d;

  logic commit_p, inc_p, cur_p;

  always_ff @(posedge CLK or negedge RST) begin
    if (!RST) begin
      sync1_q <= 3'b111;
      sync2_q <= 3'b111;
    end else begin
      sync1_q <= KEY;
      sync2_q <= sync1_q;
    end
  end

  // The counter only runs while the synchronized level disagrees with the debounced one.
  always_comb begin
    deb_d   = deb_q;
    press_d = 3'b000;
    for (int k = 0; k < 3; k++) begin
      cnt_d[k] = '0;
      if (sync2_q[k] != deb_q[k]) begin
        if (cnt_q[k] == DEB_TC) begin
          deb_d[k]   = sync2_q[k];
          press_d[k] = ~sync2_q[k];
        end else begin
          cnt_d[k] = cnt_q[k] + 1'b1;
        end
      end
    end
  end

  always_ff @(posedge CLK or negedge RST) begin
    if (!RST) begin
      deb_q   <= 3'b111;
      press_q <= 3'b000;
      for (int k = 0; k < 3; k++) begin
        cnt_q[k] <= '0;
      end
    end else begin
      deb_q   <= deb_d;
      press_q <= press_d;
      for (int k = 0; k < 3; k++) begin
        cnt_q[k] <= cnt_d[k];
      end
    end
  end

  assign commit_p = press_q[0];
  assign inc_p    = press_q[1];
  assign cur_p    = press_q[2];

  always_ff @(posedge CLK or negedge RST) begin
    if (!RST) begin
      state_q <= S_EDIT;
    end else begin
      state_q <= state_d;
    end
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      S_EDIT: if (commit_p) state_d = S_HOLD;
      S_HOLD: if (out_valid_q && out_ready) state_d = S_EDIT;
      default: state_d = S_EDIT;
    endcase
  end

  // Every update reads only the pre-edge registers, so simultaneous presses act in parallel.
  always_comb begin
    edit_d      = edit_q;
    cursor_d    = cursor_q;
    out_data_d  = out_data_q;
    out_valid_d = out_valid_q;
    if (inc_p) begin
      edit_d[{cursor_q, 2'b00} +: 4] = edit_q[{cursor_q, 2'b00} +: 4] + 4'd1;
    end
    if (cur_p) begin
      cursor_d = (cursor_q == CW'(NDIG - 1)) ? '0 : cursor_q + 1'b1;
    end
    case (state_q)
      S_EDIT: begin
        if (commit_p) begin
          out_data_d  = edit_q;
          out_valid_d = 1'b1;
        end
      end
      S_HOLD: begin
        if (out_valid_q && out_ready) begin
          out_valid_d = 1'b0;
        end
      end
      default: out_valid_d = 1'b0;
    endcase
  end

  always_ff @(posedge CLK or negedge RST) begin
    if (!RST) begin
      edit_q      <= '0;
      cursor_q    <= '0;
      out_data_q  <= '0;
      out_valid_q <= 1'b0;
    end else begin
      edit_q      <= edit_d;
      cursor_q    <= cursor_d;
      out_data_q  <= out_data_d;
      out_valid_q <= out_valid_d;
    end
  end

  assign edit_value = edit_q;
  assign cursor     = cursor_q;
  assign out_data   = out_data_q;
  assign out_valid  = out_valid_q;

`ifdef HEX_ENTRY_BLINK_EN
  localparam int BLINK_CW = $clog2(BLINK_CYCLES + 1);
  localparam logic [BLINK_CW-1:0] BLINK_TC = BLINK_CW'(BLINK_CYCLES - 1);

  logic [BLINK_CW-1:0] blink_cnt_q, blink_cnt_d;
  logic                phase_q, phase_d;
  logic [NDIG-1:0]     blank_q, blank_d;

  // blank is derived from next-state values so the registered output tracks state, cursor and phase.
  always_comb begin
    blink_cnt_d = blink_cnt_q + 1'b1;
    phase_d     = phase_q;
    if (cur_p) begin
      blink_cnt_d = '0;
      phase_d     = 1'b0;
    end else if (blink_cnt_q == BLINK_TC) begin
      blink_cnt_d = '0;
      phase_d     = ~phase_q;
    end
    blank_d = '0;
    if (state_d == S_EDIT) begin
      blank_d[cursor_d] = phase_d;
    end
  end

  always_ff @(posedge CLK or negedge RST) begin
    if (!RST) begin
      blink_cnt_q <= '0;
      phase_q     <= 1'b0;
      blank_q     <= '0;
    end else begin
      blink_cnt_q <= blink_cnt_d;
      phase_q     <= phase_d;
      blank_q     <= blank_d;
    end
  end

  assign blank = blank_q;
`else
  // BLINK_CYCLES only matters with blinking; this is constant 0 for every legal value.
  assign blank = {NDIG{BLINK_CYCLES < 0}};
`endif

endmodule

// File: tb/tb_hex_key_entry.sv
// Self-checking bench for hex_key_entry: directed test-plan cases plus random key sequences
// compared against a nibble-array reference model.
module tb_hex_key_entry;

  localparam int DW  = 8;
  localparam int DEB = 4;
  localparam int BLK = 8;

  logic          CLK = 1'b0;
  logic          RST = 1'b0;
  logic [2:0]    KEY = 3'b111;
  logic          out_ready = 1'b0;
  logic [DW-1:0] out_data;
  logic          out_valid;
  logic [DW-1:0] edit_value;
  logic [0:0]    cursor;
  logic [1:0]    blank;

  int n_checks = 0;
  int n_fail   = 0;

  // reference model
  int          m_nib [2];
  int          m_cur;
  bit          m_hold;
  int          m_data;

  hex_key_entry #(
    .DATA_W(DW), .DEB_CYCLES(DEB), .BLINK_CYCLES(BLK)
  ) dut (
    .CLK(CLK), .RST(RST), .KEY(KEY),
    .out_data(out_data), .out_valid(out_valid), .out_ready(out_ready),
    .edit_value(edit_value), .cursor(cursor), .blank(blank)
  );

  always #5 CLK = ~CLK;

  task automatic chk(input string tag, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, act, exp);
    end
  endtask

  task automatic tick(input int n);
    repeat (n) @(negedge CLK);
  endtask

  task automatic model_reset();
    m_nib[0] = 0;
    m_nib[1] = 0;
    m_cur    = 0;
    m_hold   = 0;
    m_data   = 0;
  endtask

  function automatic int model_val();
    return m_nib[1] * 16 + m_nib[0];
  endfunction

  // ready is held constant across one step, so a pending handshake completes before the press lands.
  task automatic model_step(input logic [2:0] mask, input bit rdy);
    if (m_hold && rdy) m_hold = 0;
    if (mask[0] && !m_hold) begin
      m_data = model_val();
      m_hold = 1;
    end
    if (mask[1]) m_nib[m_cur] = (m_nib[m_cur] + 1) % 16;
    if (mask[2]) m_cur = (m_cur + 1) % 2;
    if (m_hold && rdy) m_hold = 0;
  endtask

  task automatic do_reset();
    @(negedge CLK);
    KEY = 3'b111;
    out_ready = 1'b0;
    RST = 1'b0;
    tick(2);
    RST = 1'b1;
    model_reset();
  endtask

  task automatic press(input logic [2:0] mask, input bit glitch);
    if (glitch) begin
      KEY = ~mask;
      tick($urandom_range(1, DEB - 1));
      KEY = 3'b111;
      tick($urandom_range(1, 2));
    end
    KEY = ~mask;
    tick(DEB + 4);
    KEY = 3'b111;
    tick(DEB + 4);
  endtask

  task automatic presses(input logic [2:0] mask, input int n);
    repeat (n) press(mask, 1'b0);
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int exp_phase;
    logic [2:0] mask;
    bit rdy, gl;

    // reset state
    #3;
    chk("rst_edit", edit_value, 0);
    chk("rst_data", out_data, 0);
    chk("rst_valid", out_valid, 0);
    chk("rst_cursor", cursor, 0);
    chk("rst_blank", blank, 0);

    // exact press latency
    do_reset();
    KEY = 3'b101;
    for (int i = 1; i <= 7; i++) begin
      @(posedge CLK);
      #1;
      if (i == 6) chk("lat_edge6", edit_value, 8'h00);
      if (i == 7) chk("lat_edge7", edit_value, 8'h01);
    end
    tick(3);
    KEY = 3'b111;
    tick(12);
    chk("release_no_event", edit_value, 8'h01);

    // bounce then steady press
    do_reset();
    KEY = 3'b101;
    tick(3);
    KEY = 3'b111;
    tick(1);
    KEY = 3'b101;
    tick(12);
    KEY = 3'b111;
    tick(12);
    chk("bounce_one_inc", edit_value, 8'h01);

    do_reset();
    KEY = 3'b101;
    tick(3);
    KEY = 3'b111;
    tick(12);
    chk("glitch_ignored", edit_value, 8'h00);

    // nibble and cursor wrap
    do_reset();
    presses(3'b010, 15);
    chk("inc15", edit_value, 8'h0F);
    presses(3'b010, 1);
    chk("nibble_wrap", edit_value, 8'h00);
    presses(3'b100, 1);
    chk("cursor_1", cursor, 1);
    presses(3'b010, 10);
    chk("digit1_A", edit_value, 8'hA0);
    presses(3'b100, 1);
    chk("cursor_wrap", cursor, 0);

    // handshake from 0x5C
    do_reset();
    presses(3'b010, 12);
    presses(3'b100, 1);
    presses(3'b010, 5);
    presses(3'b100, 1);
    chk("setup_5C", edit_value, 8'h5C);
    presses(3'b001, 1);
    chk("commit_valid", out_valid, 1);
    chk("commit_data", out_data, 8'h5C);
    presses(3'b010, 1);
    chk("hold_edit", edit_value, 8'h5D);
    chk("hold_data", out_data, 8'h5C);
    presses(3'b001, 1);
    chk("hold_commit_ign", out_data, 8'h5C);
    chk("hold_valid", out_valid, 1);
    out_ready = 1'b1;
    @(posedge CLK);
    #1;
    chk("hs_drop", out_valid, 0);
    @(negedge CLK);
    out_ready = 1'b0;
    tick(3);
    chk("hs_stays_low", out_valid, 0);

    // simultaneous presses
    do_reset();
    presses(3'b010, 15);
    presses(3'b111, 1);
    chk("sim_data", out_data, 8'h0F);
    chk("sim_edit", edit_value, 8'h00);
    chk("sim_cursor", cursor, 1);
    chk("sim_valid", out_valid, 1);

    // reset mid-HOLD and mid-debounce
    KEY = 3'b101;
    tick(3);
    #2;
    RST = 1'b0;
    #1;
    chk("arst_edit", edit_value, 0);
    chk("arst_data", out_data, 0);
    chk("arst_valid", out_valid, 0);
    chk("arst_cursor", cursor, 0);
    chk("arst_blank", blank, 0);
    @(negedge CLK);
    KEY = 3'b111;
    tick(2);
    RST = 1'b1;
    tick(20);
    chk("no_stale_edit", edit_value, 0);
    chk("no_stale_valid", out_valid, 0);

    // blink phase after reset (constant 0 when blinking is not built in)
    do_reset();
    chk("blink_n0", blank, 0);
    for (int n = 1; n <= 20; n++) begin
      @(posedge CLK);
      #1;
`ifdef HEX_ENTRY_BLINK_EN
      exp_phase = (n / BLK) % 2;
`else
      exp_phase = 0;
`endif
      chk($sformatf("blink_n%0d", n), blank, exp_phase);
    end

    // random sequences against the model
    do_reset();
    for (int s = 0; s < 40; s++) begin
      mask = 3'($urandom_range(1, 7));
      rdy  = 1'($urandom_range(0, 1));
      gl   = 1'($urandom_range(0, 1));
      @(negedge CLK);
      out_ready = rdy;
      model_step(mask, rdy);
      press(mask, gl);
      chk($sformatf("rnd%0d_edit", s), edit_value, model_val());
      chk($sformatf("rnd%0d_cursor", s), cursor, m_cur);
      chk($sformatf("rnd%0d_valid", s), out_valid, m_hold);
      chk($sformatf("rnd%0d_data", s), out_data, m_data);
`ifndef HEX_ENTRY_BLINK_EN
      chk($sformatf("rnd%0d_blank", s), blank, 0);
`endif
    end
    out_ready = 1'b0;

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/hex_key_entry.md
# hex_key_entry

Manual data-entry block for the board: debounces the raw pushbuttons and lets the user edit a DATA_W-bit hex value one digit at a time. The block commits the value to a consumer over a valid/ready handshake, such as a CPU input port or a memory-load register. It is the input-side counterpart of the seven-segment display path. `edit_value` and `blank` drive the existing 7-segment decoders so the operator sees the value being typed.

## Interface
- `DATA_W`, default 8: value width; multiple of 4, ≥ 8; NDIG = DATA_W/4 hex digits.
- `DEB_CYCLES`, default 500000: stable-input cycles required to accept a key change (10 ms at 50 MHz).
- `BLINK_CYCLES`, default 12500000: cursor blink half-period (only used with HEX_ENTRY_BLINK_EN).

Ports (clock and reset first):
- `CLK`  in  1  system clock, single domain.
- `RST`  in  1  asynchronous, active-low reset.
- `KEY`  in  3  raw active-low pushbuttons, asynchronous to CLK:
  - KEY[0]: commit.
  - KEY[1]: increment digit.
  - KEY[2]: move cursor.
- `out_data`  out  DATA_W  committed value.
- `out_valid`  out  1  committed value available.
- `out_ready`  in  1  consumer accepts `out_data` when high with `out_valid`.
- `edit_value`  out  DATA_W  value currently being edited.
- `cursor`  out  max(1,$clog2(NDIG))  index of the digit being edited; 0 = least significant nibble.
- `blank`  out  NDIG  per-digit blank request to the display; 1 = digit dark.

## Operation
- **Input conditioning:** each KEY bit passes through a 2-FF synchronizer, then a per-key debounce counter.
  - The debounced state takes the synchronized level only after that level has differed from it for DEB_CYCLES consecutive cycles.
  - Any cycle where the synchronized level equals the debounced state clears the counter.
- **Press event:** a one-cycle internal pulse on each debounced released→pressed (1→0) transition. Releases generate nothing.
- **State machine:**
  - EDIT:
    - Increment pulse: the nibble at `cursor` becomes (nibble+1) mod 16. F wraps to 0 with no carry into the next digit.
    - Cursor pulse: `cursor` becomes (cursor+1) mod NDIG, so NDIG-1 wraps to 0.
    - Commit pulse: `out_data` ← `edit_value`, `out_valid` ← 1, go to HOLD.
  - HOLD:
    - `out_data` is frozen and commit pulses are ignored.
    - Increment and cursor pulses still edit `edit_value`.
    - When `out_valid` and `out_ready` are both high on a rising edge: `out_valid` ← 0, go to EDIT.
- **Simultaneous pulses in one cycle:**
  - All pulses act in parallel.
  - Increment acts on the pre-move cursor.
  - Commit captures the pre-increment value.
- `edit_value` is not cleared on commit.
- **Reset (asynchronous, any time, including mid-debounce or in HOLD):** all of the following are forced:
  - `out_data`, `edit_value`, `cursor`, `blank` = 0.
  - `out_valid` = 0 and state = EDIT.
  - Debounced key states = released and debounce counters = 0.
  - Synchronizers = 1 (released).
  - Blink counter and phase = 0.

## Timing
- Key latency: KEY[i] goes low and is stable before rising edge 1. The resulting `edit_value`, `cursor` or `out_valid` change is visible after edge DEB_CYCLES+3, with no earlier and no later update.
- A bounce shorter than DEB_CYCLES produces no event and restarts the count.
- `out_valid` rises after the same latency as above. It then holds until the first edge with `out_ready` = 1, and drops after that edge.
- Minimum commit-to-commit spacing: one handshake cycle plus a new debounced press.
- `out_ready` does not affect anything while `out_valid` = 0.
- All outputs are registered; there are no combinational paths from `out_ready` or KEY to any output.

## Configuration
- **`HEX_ENTRY_BLINK_EN` defined:**
  - A free-running counter toggles a blink phase every BLINK_CYCLES cycles.
  - In EDIT, `blank[cursor]` = phase; all other bits = 0.
  - In HOLD, `blank` = 0.
  - A cursor pulse clears the counter and phase, so the newly selected digit is lit immediately.
- **Not defined:** `blank` is constant 0, and no blink counter is synthesized.

## Test plan
Benches use DEB_CYCLES=4, BLINK_CYCLES=8, DATA_W=8.
- Clean press on KEY[1] at reset → `edit_value` = 0x01 exactly 7 edges after the first low sample. Release → no change.
- Bounce: KEY[1] low for 3 cycles, high for 1, then low steadily → exactly one increment. A 3-cycle glitch alone → `edit_value` stays 0x00.
- Wrap-around:
  - 16 increments → nibble 0 returns to 0x0, and `edit_value` = 0x00 with no carry.
  - Cursor press then 10 increments → `edit_value` = 0xA0.
  - A second cursor press → `cursor` wraps to 0.
- Handshake, starting from `edit_value` = 0x5C:
  - Commit with `out_ready` = 0 → `out_valid` = 1 and `out_data` = 0x5C.
  - Increment during HOLD → `edit_value` = 0x5D, `out_data` stays 0x5C.
  - Commit ignored during HOLD.
  - `out_ready` = 1 for one cycle → `out_valid` drops after that edge.
- Simultaneous press, with `edit_value` = 0x0F and `cursor` = 0: KEY[0], KEY[1] and KEY[2] pressed together →
  - `out_data` = 0x0F.
  - `edit_value` = 0x00.
  - `cursor` = 1.
- Reset mid-HOLD and mid-debounce → all outputs 0 immediately. After release no stale event fires. With `HEX_ENTRY_BLINK_EN`, `blank` = 2'b00 then 2'b01 toggling every 8 cycles.
